// File: rtl/pad_ctrl_pkg.sv
// Shared register map, lock key and reset defaults for the pad control block.
package pad_ctrl_pkg;

  localparam logic [7:0] OFS_DS0     = 8'h00;
  localparam logic [7:0] OFS_DS1     = 8'h04;
  localparam logic [7:0] OFS_PE      = 8'h08;
  localparam logic [7:0] OFS_PS      = 8'h0C;
  localparam logic [7:0] OFS_IS      = 8'h10;
  localparam logic [7:0] OFS_SR      = 8'h14;
  localparam logic [7:0] OFS_OE      = 8'h18;
  localparam logic [7:0] OFS_IE      = 8'h1C;
  localparam logic [7:0] OFS_DOUT    = 8'h20;
  localparam logic [7:0] OFS_DIN     = 8'h24;
  localparam logic [7:0] OFS_INT_EN  = 8'h28;
  localparam logic [7:0] OFS_INT_STS = 8'h2C;
  localparam logic [7:0] OFS_LOCK    = 8'h30;

  localparam logic [7:0] LOCK_KEY = 8'h5A;

  // The eight lockable configuration registers DS0..IE, held as one array.
  localparam int unsigned CFG_NUM = 8;
  // Bit k set: configuration register k resets to all-ones (PE and IE).
  localparam logic [CFG_NUM-1:0] CFG_RST_ONES = 8'b1000_0100;

  // Register selected by an access; the order matches the word offset.
  typedef enum logic [3:0] {
    SEL_DS0, SEL_DS1, SEL_PE, SEL_PS, SEL_IS, SEL_SR, SEL_OE, SEL_IE,
    SEL_DOUT, SEL_DIN, SEL_INT_EN, SEL_INT_STS, SEL_LOCK, SEL_NONE
  } reg_sel_e;

  // Map a byte offset to a register; misaligned or out-of-range is SEL_NONE.
  function automatic reg_sel_e decode_ofs(input logic [31:0] ofs);
    if (ofs[1:0] != 2'b00 || ofs > 32'(OFS_LOCK)) return SEL_NONE;
    return reg_sel_e'(ofs[5:2]);
  endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Two-flop synchroniser for the pad returns plus rising-edge detection.
module pad_in_sync #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pad_y,
  output logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;
  logic [W-1:0] din_d;

  // Synchroniser chain followed by a one-cycle delay for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= '0;
      din   <= '0;
      din_d <= '0;
    end else begin
      meta  <= pad_y;
      din   <= meta;
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/pad_ctrl_regs.sv
// APB pad configuration / GPIO register block driving pad_top.
module pad_ctrl_regs
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PAD = 10,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [ADDR_W-1:0]  PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic [NUM_PAD-1:0] pad_a,
  output logic [NUM_PAD-1:0] pad_oe,
  output logic [NUM_PAD-1:0] pad_ie,
  input  logic [NUM_PAD-1:0] pad_y,
  output logic [NUM_PAD-1:0] control_DS0,
  output logic [NUM_PAD-1:0] control_DS1,
  output logic [NUM_PAD-1:0] control_PE,
  output logic [NUM_PAD-1:0] control_PS,
  output logic [NUM_PAD-1:0] control_IS,
  output logic [NUM_PAD-1:0] control_SR,
  output logic               irq
);

  logic [NUM_PAD-1:0] cfg [CFG_NUM];
  logic [NUM_PAD-1:0] dout;
  logic [NUM_PAD-1:0] int_en;
  logic [NUM_PAD-1:0] int_sts;
  logic               lock;

  logic [NUM_PAD-1:0] din;
  logic [NUM_PAD-1:0] rise;

  reg_sel_e           sel;
  logic [2:0]         cfg_idx;
  logic               rd_setup;
  logic               access;
  logic               err;
  logic               wr_en;
  logic [NUM_PAD-1:0] wdata;
  logic [NUM_PAD-1:0] sts_clr;
  logic [NUM_PAD-1:0] sts_next;
  logic [31:0]        rdata;

  pad_in_sync #(.W(NUM_PAD)) u_sync (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .pad_y (pad_y),
    .din   (din),
    .rise  (rise)
  );

  assign sel     = decode_ofs(32'(PADDR));
  assign cfg_idx = 3'(sel);
  assign PREADY  = 1'b1;

  // APB decode, error response, W1C/set merge and read-data mux.
  always_comb begin
    rd_setup = PSEL & ~PENABLE & ~PWRITE;
    access   = PSEL & PENABLE;
    err      = (sel == SEL_NONE)
             | (PWRITE & (sel == SEL_DIN))
             | (PWRITE & lock & (sel <= SEL_IE));
    PSLVERR  = access & err;
    wr_en    = access & PWRITE & ~err;
    wdata    = PWDATA[NUM_PAD-1:0];
    sts_clr  = (wr_en && sel == SEL_INT_STS) ? wdata : '0;
    // The new-rise set term is OR'd after the clear so a same-cycle set wins.
    sts_next = (int_sts & ~sts_clr) | (rise & int_en);

    rdata = '0;
    case (sel)
      SEL_DS0, SEL_DS1, SEL_PE, SEL_PS,
      SEL_IS, SEL_SR, SEL_OE, SEL_IE: rdata[NUM_PAD-1:0] = cfg[cfg_idx];
      SEL_DOUT:    rdata[NUM_PAD-1:0] = dout;
      SEL_DIN:     rdata[NUM_PAD-1:0] = din;
      SEL_INT_EN:  rdata[NUM_PAD-1:0] = int_en;
      SEL_INT_STS: rdata[NUM_PAD-1:0] = int_sts;
      SEL_LOCK:    rdata[0]           = lock;
      default:     rdata              = '0;
    endcase
  end

  // Register file, lock, interrupt status/irq and registered read data.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned k = 0; k < CFG_NUM; k++) begin
        cfg[k] <= CFG_RST_ONES[k[2:0]] ? '1 : '0;
      end
      dout    <= '0;
      int_en  <= '0;
      int_sts <= '0;
      lock    <= 1'b0;
      irq     <= 1'b0;
      PRDATA  <= '0;
    end else begin
      if (rd_setup) PRDATA <= rdata;
      int_sts <= sts_next;
      irq     <= |(int_sts & int_en);
      if (wr_en) begin
        case (sel)
          SEL_DS0, SEL_DS1, SEL_PE, SEL_PS,
          SEL_IS, SEL_SR, SEL_OE, SEL_IE: cfg[cfg_idx] <= wdata;
          SEL_DOUT:   dout   <= wdata;
          SEL_INT_EN: int_en <= wdata;
          SEL_LOCK:   if (PWDATA == {24'h0, LOCK_KEY}) lock <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign pad_a       = dout;
  assign pad_oe      = cfg[6];
  assign pad_ie      = cfg[7];
  assign control_DS0 = cfg[0];
  assign control_DS1 = cfg[1];
  assign control_PE  = cfg[2];
  assign control_PS  = cfg[3];
  assign control_IS  = cfg[4];
  assign control_SR  = cfg[5];

endmodule

// File: tb/tb_pad_ctrl_regs.sv
// Randomised APB bench for pad_ctrl_regs with a word-level reference model.
module tb_pad_ctrl_regs;

  localparam int unsigned NUM_PAD = 10;
  localparam int unsigned ADDR_W  = 8;
  localparam logic [31:0] MASK    = 32'h0000_03FF;

  logic               PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0]  PADDR;
  logic [31:0]        PWDATA, PRDATA;
  logic               PREADY, PSLVERR, irq;
  logic [NUM_PAD-1:0] pad_a, pad_oe, pad_ie, pad_y;
  logic [NUM_PAD-1:0] control_DS0, control_DS1, control_PE;
  logic [NUM_PAD-1:0] control_PS, control_IS, control_SR;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // Reference model state: one word per offset/4, plus sampled pad history.
  logic [31:0] m_reg [13];
  logic        m_lock, m_irq;
  logic [31:0] m_prdata;
  logic [31:0] y_q [$];

  pad_ctrl_regs #(.NUM_PAD(NUM_PAD), .ADDR_W(ADDR_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .pad_a(pad_a), .pad_oe(pad_oe),
    .pad_ie(pad_ie), .pad_y(pad_y), .control_DS0(control_DS0),
    .control_DS1(control_DS1), .control_PE(control_PE), .control_PS(control_PS),
    .control_IS(control_IS), .control_SR(control_SR), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [7:0] a, input logic wr);
    if (a[1:0] != 2'b00 || a > 8'h30) return 1'b1;
    if (wr && a == 8'h24) return 1'b1;
    if (wr && a <= 8'h1C && m_lock) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (m_err(a, 1'b0)) return 32'h0;
    if (a == 8'h24) return y_q[1];
    if (a == 8'h30) return {31'h0, m_lock};
    return m_reg[int'(a >> 2)];
  endfunction

  task m_reset();
    for (int i = 0; i < 13; i++) m_reg[i] = 32'h0;
    m_reg[2] = MASK;
    m_reg[7] = MASK;
    m_lock   = 1'b0;
    m_irq    = 1'b0;
    m_prdata = 32'h0;
    y_q      = '{32'h0, 32'h0, 32'h0};
  endtask

  // Model update at each clock edge; y_q[0] is the newest pad sample, y_q[1] is DIN.
  always @(posedge PCLK) begin : model
    logic [31:0] rise_v, set_v, clr_v;
    logic        irq_v;
    if (!PRESETn) begin
      m_reset();
    end else begin
      rise_v = y_q[1] & ~y_q[2];
      set_v  = rise_v & m_reg[10];
      clr_v  = 32'h0;
      irq_v  = |(m_reg[11] & m_reg[10]);
      if (PSEL && !PENABLE && !PWRITE) m_prdata = m_read(PADDR);
      if (PSEL && PENABLE && PWRITE && !m_err(PADDR, 1'b1)) begin
        case (PADDR)
          8'h30:   if (PWDATA == 32'h5A) m_lock = 1'b1;
          8'h2C:   clr_v = PWDATA & MASK;
          default: m_reg[int'(PADDR >> 2)] = PWDATA & MASK;
        endcase
      end
      m_reg[11] = (m_reg[11] & ~clr_v) | set_v;
      m_irq = irq_v;
      y_q.push_front(32'(pad_y) & MASK);
      void'(y_q.pop_back());
    end
  end

  // Continuous comparison of every output, sampled just before the next rising edge.
  always @(negedge PCLK) begin
    #3;
    if (chk_en) begin
      check_val("pad_a",   32'(pad_a),       m_reg[8]);
      check_val("pad_oe",  32'(pad_oe),      m_reg[6]);
      check_val("pad_ie",  32'(pad_ie),      m_reg[7]);
      check_val("ds0",     32'(control_DS0), m_reg[0]);
      check_val("ds1",     32'(control_DS1), m_reg[1]);
      check_val("pe",      32'(control_PE),  m_reg[2]);
      check_val("ps",      32'(control_PS),  m_reg[3]);
      check_val("is",      32'(control_IS),  m_reg[4]);
      check_val("sr",      32'(control_SR),  m_reg[5]);
      check_val("irq",     32'(irq),         32'(m_irq));
      check_val("prdata",  PRDATA,           m_prdata);
      check_val("pready",  32'(PREADY),      32'h1);
      check_val("pslverr", 32'(PSLVERR),
                (PSEL && PENABLE) ? 32'(m_err(PADDR, PWRITE)) : 32'h0);
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #3 e = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #3 begin e = PSLVERR; d = PRDATA; end
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rand_txn(input bit allow_key);
    logic [7:0]  a;
    logic [31:0] d;
    logic        e;
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 13)      a = 8'(r * 4);
    else if (r < 16) a = 8'(32'h34 + (r - 13) * 4);
    else             a = 8'($urandom_range(0, 255));
    d = $urandom();
    if (a == 8'h30) begin
      if (allow_key && $urandom_range(0, 3) == 0) d = 32'h5A;
      else if (d == 32'h5A) d = 32'h5B;
    end
    if ($urandom_range(0, 1) == 1) apb_write(a, d, e);
    else                           apb_read(a, d, e);
    if ($urandom_range(0, 3) == 0) pad_y = NUM_PAD'($urandom());
    repeat ($urandom_range(0, 1)) @(posedge PCLK);
  endtask

  task automatic check_reset_map(input string tag);
    logic [31:0] d;
    logic        e;
    for (int i = 0; i < 13; i++) begin
      apb_read(8'(i * 4), d, e);
      check_val(tag, d, (i == 2 || i == 7) ? MASK : 32'h0);
      check_val({tag, "_err"}, 32'(e), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; pad_y = '0;
    @(posedge PCLK);
    #1 chk_en = 1'b1;
    @(negedge PCLK) PRESETn = 1'b1;

    // Reset map and pad outputs.
    check_reset_map("rst_rd");
    check_val("rst_oe", 32'(pad_oe), 32'h0);
    check_val("rst_ie", 32'(pad_ie), 32'h3FF);

    // Upper bits of a write are dropped.
    apb_write(8'h00, 32'hFFFF_FFFF, e);
    check_val("ds0_pad", 32'(control_DS0), 32'h3FF);
    apb_read(8'h00, d, e);
    check_val("ds0_rd", d, 32'h3FF);

    for (int i = 0; i < 500; i++) rand_txn(1'b0);

    // Near-miss key must not lock.
    apb_write(8'h30, 32'h0000_015A, e);
    check_val("lock_near_err", 32'(e), 32'h0);
    apb_read(8'h30, d, e);
    check_val("lock_near", d, 32'h0);

    // Rising edge to irq latency and W1C.
    pad_y = '0;
    apb_write(8'h28, 32'h1, e);
    repeat (5) @(posedge PCLK);
    apb_write(8'h2C, 32'h3FF, e);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK) pad_y = 10'h001;
    repeat (3) @(posedge PCLK);
    #1 check_val("irq_e3", 32'(irq), 32'h0);
    @(posedge PCLK);
    #1 check_val("irq_e4", 32'(irq), 32'h1);
    apb_read(8'h24, d, e);
    check_val("din", d, 32'h001);
    apb_read(8'h2C, d, e);
    check_val("sts_set", d, 32'h001);
    apb_write(8'h2C, 32'h1, e);
    check_val("irq_w1c_hold", 32'(irq), 32'h1);
    @(posedge PCLK);
    #1 check_val("irq_w1c", 32'(irq), 32'h0);

    // W1C coinciding with a new rise: set wins.
    pad_y = '0;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK) pad_y = 10'h001;
    @(posedge PCLK);
    apb_write(8'h2C, 32'h1, e);
    apb_read(8'h2C, d, e);
    check_val("sts_set_wins", d, 32'h001);
    apb_write(8'h2C, 32'h3FF, e);

    // Lock.
    apb_write(8'h14, 32'h0, e);
    apb_write(8'h30, 32'h5A, e);
    check_val("lock_wr_err", 32'(e), 32'h0);
    apb_write(8'h14, 32'h1, e);
    check_val("sr_locked_err", 32'(e), 32'h1);
    apb_read(8'h14, d, e);
    check_val("sr_locked", d, 32'h0);
    apb_write(8'h20, 32'h2A5, e);
    check_val("dout_err", 32'(e), 32'h0);
    check_val("dout_pad", 32'(pad_a), 32'h2A5);
    apb_read(8'h30, d, e);
    check_val("lock_rd", d, 32'h1);

    for (int i = 0; i < 300; i++) rand_txn(1'b1);

    // Error responses.
    apb_read(8'h34, d, e);
    check_val("unmap_rd_err", 32'(e), 32'h1);
    apb_write(8'h34, 32'h3FF, e);
    check_val("unmap_wr_err", 32'(e), 32'h1);
    apb_write(8'h24, 32'h3FF, e);
    check_val("din_wr_err", 32'(e), 32'h1);
    apb_write(8'h21, 32'h3FF, e);
    check_val("misalign_err", 32'(e), 32'h1);

    // Reset during a write access cycle.
    pad_y = '0;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 32'h155;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK);
    #1 begin PSEL = 1'b0; PENABLE = 1'b0; end
    check_val("rst_mid_pad_a", 32'(pad_a), 32'h0);
    @(negedge PCLK) PRESETn = 1'b1;
    check_reset_map("rst_mid_rd");

    for (int i = 0; i < 150; i++) rand_txn(1'b1);

    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
